// File: rtl/inst_encoder_loader_pkg.sv
// Shared definitions for the instruction encoder/loader: opcode constants,
// instruction format and loader state encodings, field bit positions and
// the opcode legality table used when INST_LOADER_OPCODE_CHECK_EN is defined.
package inst_encoder_loader_pkg;

  localparam logic [5:0] OP_RTYPE    = 6'h00;
  localparam logic [5:0] OP_REGIMM   = 6'h01;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_BLEZ     = 6'h06;
  localparam logic [5:0] OP_BGTZ     = 6'h07;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_ADDIU    = 6'h09;
  localparam logic [5:0] OP_SLTI     = 6'h0a;
  localparam logic [5:0] OP_SLTIU    = 6'h0b;
  localparam logic [5:0] OP_ANDI     = 6'h0c;
  localparam logic [5:0] OP_ORI      = 6'h0d;
  localparam logic [5:0] OP_XORI     = 6'h0e;
  localparam logic [5:0] OP_LUI      = 6'h0f;
  localparam logic [5:0] OP_OP1C     = 6'h1c;  // legacy multiply group, I-format
  localparam logic [5:0] OP_SPECIAL2 = 6'h1f;  // R-format extension group
  localparam logic [5:0] OP_LB       = 6'h20;
  localparam logic [5:0] OP_LH       = 6'h21;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_SB       = 6'h28;
  localparam logic [5:0] OP_SH       = 6'h29;
  localparam logic [5:0] OP_SW       = 6'h2b;

  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned SHAMT_LSB = 6;

  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J} fmt_t;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WRITE, ST_DONE} state_t;

  function automatic logic opcode_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
      OP_OP1C, OP_SPECIAL2, OP_LB, OP_LH, OP_LW, OP_SB, OP_SH, OP_SW:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/inst_encoder_loader_word_pack.sv
// Combinational field packer: selects R/I/J format from the opcode and builds
// the 32-bit MIPS word. With INST_LOADER_OPCODE_CHECK_EN defined, legal
// reflects the supported-opcode table; otherwise every opcode is legal.
import inst_encoder_loader_pkg::*;

module inst_word_pack (
  input  logic [5:0]  opcode,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  fmt_t fmt;

  // Format selection and word assembly
  always_comb begin
    case (opcode)
      OP_RTYPE, OP_SPECIAL2: fmt = FMT_R;
      OP_J, OP_JAL:          fmt = FMT_J;
      default:               fmt = FMT_I;
    endcase

    word = 32'(opcode) << OP_LSB;
    case (fmt)
      FMT_R: word = word | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB)
                         | (32'(rd) << RD_LSB) | (32'(shamt) << SHAMT_LSB)
                         | 32'(funct);
      FMT_J: word = word | 32'(target);
      default: word = word | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB)
                           | 32'(imm);
    endcase
  end

`ifdef INST_LOADER_OPCODE_CHECK_EN
  assign legal = opcode_legal(opcode);
`else
  assign legal = 1'b1;
`endif

endmodule

// File: rtl/inst_encoder_loader.sv
// Sequential instruction encoder/loader: accepts field bundles over a
// valid/ready handshake, packs them into MIPS words and writes them to
// consecutive word addresses from BASE_ADDR, at most DEPTH per session.
// Optional opcode screening: INST_LOADER_OPCODE_CHECK_EN (see inst_word_pack).
import inst_encoder_loader_pkg::*;

module inst_encoder_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 256
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic        InValid,
  output logic        InReady,
  input  logic [5:0]  InOpcode,
  input  logic [4:0]  InRs,
  input  logic [4:0]  InRt,
  input  logic [4:0]  InRd,
  input  logic [4:0]  InShamt,
  input  logic [5:0]  InFunct,
  input  logic [15:0] InImm,
  input  logic [25:0] InTarget,
  input  logic        InLast,
  output logic        WrEn,
  output logic [31:0] WrAddr,
  output logic [31:0] WrData,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] Count,
  output logic        Overflow,
  output logic        ErrIllegal
);

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  state_t      state;
  logic [31:0] addr;
  logic [31:0] data_q;
  logic        last_q;
  logic [15:0] count;
  logic        overflow;
  logic        err;
  logic        full;
  logic [31:0] packed_word;
  logic        packed_legal;

  inst_word_pack u_pack (
    .opcode (InOpcode),
    .rs     (InRs),
    .rt     (InRt),
    .rd     (InRd),
    .shamt  (InShamt),
    .funct  (InFunct),
    .imm    (InImm),
    .target (InTarget),
    .word   (packed_word),
    .legal  (packed_legal)
  );

  assign full = (count == DEPTH_W);

  // Session FSM: handshake, write strobe, address/count and sticky flags
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= ST_IDLE;
      addr     <= BASE_ADDR;
      data_q   <= '0;
      last_q   <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (Start) begin
            state    <= ST_LOAD;
            addr     <= BASE_ADDR;
            count    <= '0;
            overflow <= 1'b0;
            err      <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (InValid) begin
            if (full) begin
              overflow <= 1'b1;
              state    <= ST_DONE;
            end else if (packed_legal) begin
              data_q <= packed_word;
              last_q <= InLast;
              state  <= ST_WRITE;
            end else begin
              err   <= 1'b1;
              state <= InLast ? ST_DONE : ST_LOAD;
            end
          end else if (full) begin
            state <= ST_DONE;
          end
        end
        ST_WRITE: begin
          addr  <= addr + 32'd4;
          count <= count + 16'd1;
          // A full session without InLast passes through LOAD for one cycle
          // with InReady low, so a bundle still being offered is flagged as
          // Overflow; with nothing offered it settles in DONE right after.
          state <= last_q ? ST_DONE : ST_LOAD;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign InReady    = (state == ST_LOAD) && !full;
  assign WrEn       = (state == ST_WRITE);
  assign WrAddr     = addr;
  assign WrData     = data_q;
  assign Busy       = (state == ST_LOAD) || (state == ST_WRITE);
  assign Done       = (state == ST_DONE);
  assign Count      = count;
  assign Overflow   = overflow;
  assign ErrIllegal = err;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed bench for inst_encoder_loader (DEPTH=4, BASE_ADDR=0x1000).
// Honours INST_LOADER_OPCODE_CHECK_EN for the illegal-opcode expectations.
module tb_inst_encoder_loader;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Start = 1'b0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [5:0]  InOpcode = '0;
  logic [4:0]  InRs = '0, InRt = '0, InRd = '0, InShamt = '0;
  logic [5:0]  InFunct = '0;
  logic [15:0] InImm = '0;
  logic [25:0] InTarget = '0;
  logic        InLast = 1'b0;
  logic        WrEn;
  logic [31:0] WrAddr, WrData;
  logic        Busy, Done, Overflow, ErrIllegal;
  logic [15:0] Count;

  int unsigned tests = 0;
  int unsigned errors = 0;
  logic [63:0] exp_q[$];
  logic        hs_prev = 1'b0;

  inst_encoder_loader #(.BASE_ADDR(BASE), .DEPTH(4)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .InValid(InValid), .InReady(InReady),
    .InOpcode(InOpcode), .InRs(InRs), .InRt(InRt), .InRd(InRd),
    .InShamt(InShamt), .InFunct(InFunct), .InImm(InImm), .InTarget(InTarget),
    .InLast(InLast), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .Busy(Busy), .Done(Done), .Count(Count), .Overflow(Overflow),
    .ErrIllegal(ErrIllegal)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Write monitor: each write must follow a handshake by one cycle and match
  // the next expected {addr,data}.
  always @(negedge Clk) begin
    logic        hs_now;
    logic [63:0] e;
    hs_now = InValid && InReady;
    if (WrEn) begin
      check("wr_latency", 32'(hs_prev), 32'd1);
      if (exp_q.size() == 0) begin
        check("wr_pending", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", WrAddr, e[63:32]);
        check("wr_data", WrData, e[31:0]);
      end
    end
    hs_prev = hs_now;
  end

  // All tasks are entered and left at posedge+1.
  task automatic pulse_start();
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic send(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                      input logic [15:0] imm, input logic [25:0] tgt, input logic last,
                      input int unsigned gap);
    bit ok = 1'b0;
    repeat (gap) begin @(posedge Clk); #1; end
    InOpcode = op; InRs = rs; InRt = rt; InRd = rd; InShamt = sh;
    InFunct = fn; InImm = imm; InTarget = tgt; InLast = last;
    InValid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (InReady) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("handshake_timeout", 32'(InReady), 32'd1);
    @(posedge Clk); #1;
    InValid = 1'b0;
    InLast = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (Done) break;
      @(posedge Clk); #1;
    end
    check(tag, 32'(Done), 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge Clk);
    #1;
    // Reset state
    check("rst_inready", 32'(InReady), 32'd0);
    check("rst_wren", 32'(WrEn), 32'd0);
    check("rst_wraddr", WrAddr, BASE);
    check("rst_wrdata", WrData, 32'd0);
    check("rst_busy_done", {Busy, Done, Overflow, ErrIllegal}, 32'd0);
    check("rst_count", 32'(Count), 32'd0);
    Rst = 1'b0;
    @(posedge Clk); #1;

    // Start and InValid together in IDLE: bundle waits for LOAD
    InValid = 1'b1;
    pulse_start();
    check("start_busy", 32'(Busy), 32'd1);
    check("start_nowrite", 32'(WrEn), 32'd0);
    InValid = 1'b0;

    // Single R bundle: add $3,$1,$2
    exp_q.push_back({BASE, 32'h0022_1820});
    send(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b1, 0);
    wait_done("r_done");
    check("r_count", 32'(Count), 32'd1);
    check("r_busy", 32'(Busy), 32'd0);

    // addi / j / jal; Start pulsed mid-session must be ignored
    pulse_start();
    exp_q.push_back({BASE,         32'h2008_0005});
    exp_q.push_back({BASE + 32'd4, 32'h0800_0100});
    exp_q.push_back({BASE + 32'd8, 32'h0C00_0040});
    send(6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0005, 26'h0, 1'b0, 0);
    pulse_start();
    send(6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h100, 1'b0, 0);
    send(6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h040, 1'b1, 0);
    wait_done("ijj_done");
    check("ijj_count", 32'(Count), 32'd3);

    // Overflow: four words then a fifth offered with InValid held
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({BASE + 32'(4 * k), 32'h2400_0000 | 32'(k)});
      send(6'h09, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'(k), 26'h0, 1'b0, 0);
    end
    InOpcode = 6'h09; InImm = 16'h00AA; InValid = 1'b1;
    @(negedge Clk);                 // WRITE of fourth word
    @(negedge Clk);                 // LOAD at Count == DEPTH
    check("ovf_inready", 32'(InReady), 32'd0);
    @(posedge Clk); #1;
    InValid = 1'b0;
    check("ovf_flag", 32'(Overflow), 32'd1);
    check("ovf_done", 32'(Done), 32'd1);
    check("ovf_count", 32'(Count), 32'd4);

    // Restart clears sticky flags; random back-pressure session
    pulse_start();
    check("restart_ovf_clr", 32'(Overflow), 32'd0);
    exp_q.push_back({BASE,         32'h8FA8_FFFC});
    exp_q.push_back({BASE + 32'd4, 32'h7C85_31FF});
    exp_q.push_back({BASE + 32'd8, 32'h1022_0003});
    send(6'h23, 5'd29, 5'd8, 5'd0, 5'd0, 6'h0, 16'hFFFC, 26'h0, 1'b0, $urandom_range(0, 3));
    send(6'h1f, 5'd4, 5'd5, 5'd6, 5'd7, 6'h3f, 16'h0, 26'h0, 1'b0, $urandom_range(0, 3));
    send(6'h04, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0003, 26'h0, 1'b1, $urandom_range(0, 3));
    wait_done("rand_done");
    check("rand_count", 32'(Count), 32'd3);

    // Unsupported opcode 6'h3f mid-stream
    pulse_start();
    exp_q.push_back({BASE, 32'h3464_00FF});
`ifdef INST_LOADER_OPCODE_CHECK_EN
    exp_q.push_back({BASE + 32'd4, 32'hAFBF_0010});
`else
    exp_q.push_back({BASE + 32'd4, 32'hFC22_1234});
    exp_q.push_back({BASE + 32'd8, 32'hAFBF_0010});
`endif
    send(6'h0d, 5'd3, 5'd4, 5'd0, 5'd0, 6'h0, 16'h00FF, 26'h0, 1'b0, 0);
    send(6'h3f, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h1234, 26'h0, 1'b0, 0);
    send(6'h2b, 5'd29, 5'd31, 5'd0, 5'd0, 6'h0, 16'h0010, 26'h0, 1'b1, 0);
    wait_done("ill_done");
`ifdef INST_LOADER_OPCODE_CHECK_EN
    check("ill_err", 32'(ErrIllegal), 32'd1);
    check("ill_count", 32'(Count), 32'd2);
`else
    check("ill_err", 32'(ErrIllegal), 32'd0);
    check("ill_count", 32'(Count), 32'd3);
`endif

    // Reset asserted during WRITE
    pulse_start();
    exp_q.push_back({BASE, 32'h3C01_BEEF});
    send(6'h0f, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'hBEEF, 26'h0, 1'b0, 0);
    check("rstw_in_write", 32'(WrEn), 32'd1);
    Rst = 1'b1;
    @(posedge Clk); #1;
    check("rstw_wren", 32'(WrEn), 32'd0);
    check("rstw_wraddr", WrAddr, BASE);
    check("rstw_wrdata", WrData, 32'd0);
    check("rstw_flags", {InReady, Busy, Done, Overflow, ErrIllegal}, 32'd0);
    check("rstw_count", 32'(Count), 32'd0);
    Rst = 1'b0;
    @(posedge Clk); #1;
    @(negedge Clk);
    check("rstw_idle_wren", 32'(WrEn), 32'd0);
    check("exp_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
